// File: rtl/mux8_scan_ctrl.sv
// Sequencer that walks the select lines of an external 8x1 mux and collects one bit per channel.
// Each channel gets SETTLE cycles of settling and then one sampling cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start; sel held at 0
// S_SETTLE | sel is stable and the mux output settles; cnt counts up to SETTLE-1
// S_SAMPLE | mux_y is captured into shd[sel]; then advance sel or finish
// S_DONE   | one-cycle done pulse; data_out already carries the new result

module mux8_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_y,
    output logic [2:0] sel,
    output logic       busy,
    output logic [7:0] data_out,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);
    localparam logic [2:0] SEL_LAST = 3'd7;

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] shd;
    logic [7:0] shd_next;

    // The last channel's bit must reach data_out on the same edge as shd.
    always_comb begin
        shd_next      = shd;
        shd_next[sel] = mux_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sel      <= 3'd0;
            cnt      <= 4'd0;
            shd      <= 8'd0;
            data_out <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    sel  <= 3'd0;
                    if (start) begin
                        state <= S_SETTLE;
                        cnt   <= 4'd0;
                        shd   <= 8'd0;
                        busy  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    shd <= shd_next;
                    if (sel == SEL_LAST) begin
                        state    <= S_DONE;
                        data_out <= shd_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state <= S_SETTLE;
                        sel   <= sel + 3'd1;
                        cnt   <= 4'd0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    sel   <= 3'd0;
                end
                default: begin
                    state <= S_IDLE;
                    sel   <= 3'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl: one instance at SETTLE=2, one at SETTLE=1 for continuous scanning.

module tb_mux8_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] mux_pat;
    logic       mux_y;
    logic [2:0] sel;
    logic       busy, done;
    logic [7:0] data_out;

    logic       rst1, start1;
    logic [2:0] sel1;
    logic       busy1, done1;
    logic [7:0] data_out1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    assign mux_y = mux_pat[sel];

    mux8_scan_ctrl #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .mux_y(mux_y),
        .sel(sel), .busy(busy), .data_out(data_out), .done(done)
    );

    mux8_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .mux_y(1'b1),
        .sel(sel1), .busy(busy1), .data_out(data_out1), .done(done1)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, name, obs, exp);
        end
    endtask

    // Full scan at SETTLE=2: start accepted at edge k, done at edge k+24.
    task automatic scan_check(input string tag, input logic [7:0] pat, input logic [7:0] prev,
                              input logic [7:0] exp, input bit stray);
        int d0;
        mux_pat = pat;
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 24; j++) begin
            if (stray && j == 4) start = 1'b1;
            if (stray && j == 5) start = 1'b0;
            chk(tag, "sel", 32'(sel), 32'(j / 3));
            chk(tag, "busy", 32'(busy), 32'd1);
            chk(tag, "done_early", 32'(done), 32'd0);
            chk(tag, "data_hold", 32'(data_out), 32'(prev));
            step();
        end
        chk(tag, "done", 32'(done), 32'd1);
        chk(tag, "busy_done", 32'(busy), 32'd0);
        chk(tag, "data", 32'(data_out), 32'(exp));
        chk(tag, "sel_done", 32'(sel), 32'd7);
        step();
        chk(tag, "done_fall", 32'(done), 32'd0);
        chk(tag, "sel_idle", 32'(sel), 32'd0);
        chk(tag, "busy_idle", 32'(busy), 32'd0);
        chk(tag, "data_keep", 32'(data_out), 32'(exp));
        chk(tag, "done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mux_pat = 8'h00;
        rst1 = 1'b1; start1 = 1'b0;
        #1;
        chk("reset", "sel", 32'(sel), 32'd0);
        chk("reset", "data", 32'(data_out), 32'h00);
        chk("reset", "busy", 32'(busy), 32'd0);
        chk("reset", "done", 32'(done), 32'd0);
        step();
        step();
        rst = 1'b0;

        scan_check("pattern", 8'b0100_1101, 8'h00, 8'h4D, 1'b0);

        scan_check("walk0", 8'h01, 8'h4D, 8'h01, 1'b0);
        scan_check("walk1", 8'h02, 8'h01, 8'h02, 1'b0);
        scan_check("walk2", 8'h04, 8'h02, 8'h04, 1'b0);
        scan_check("walk3", 8'h08, 8'h04, 8'h08, 1'b0);
        scan_check("walk4", 8'h10, 8'h08, 8'h10, 1'b0);
        scan_check("walk5", 8'h20, 8'h10, 8'h20, 1'b0);
        scan_check("walk6", 8'h40, 8'h20, 8'h40, 1'b0);
        scan_check("walk7", 8'h80, 8'h40, 8'h80, 1'b0);

        scan_check("stray", 8'hA5, 8'h80, 8'hA5, 1'b1);
        repeat (4) begin
            step();
            chk("stray", "no_queue_busy", 32'(busy), 32'd0);
            chk("stray", "no_queue_done", 32'(done), 32'd0);
        end

        // Abort mid-scan with an asynchronous reset after edge k+10.
        mux_pat = 8'hFF;
        begin
            int d0;
            d0 = done_cnt;
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (10) step();
            chk("abort", "busy_before", 32'(busy), 32'd1);
            chk("abort", "sel_before", 32'(sel), 32'd3);
            rst = 1'b1;
            #1;
            chk("abort", "sel", 32'(sel), 32'd0);
            chk("abort", "data", 32'(data_out), 32'h00);
            chk("abort", "busy", 32'(busy), 32'd0);
            chk("abort", "done", 32'(done), 32'd0);
            step();
            rst = 1'b0;
            repeat (30) begin
                step();
                chk("abort", "no_done", 32'(done), 32'd0);
            end
            chk("abort", "done_pulses", 32'(done_cnt - d0), 32'd0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        scan_check("after_rst", 8'h3C, 8'h00, 8'h3C, 1'b0);

        // Continuous scanning at SETTLE=1: done every 18 edges.
        rst1 = 1'b0;
        start1 = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            chk("cont", "busy_first", 32'(busy1), 32'd1);
            chk("cont", "done_first", 32'(done1), 32'd0);
            step();
        end
        chk("cont", "done_0", 32'(done1), 32'd1);
        chk("cont", "busy_0", 32'(busy1), 32'd0);
        chk("cont", "data_0", 32'(data_out1), 32'hFF);
        for (int p = 0; p < 2; p++) begin
            step();
            chk("cont", "idle_busy", 32'(busy1), 32'd0);
            chk("cont", "idle_done", 32'(done1), 32'd0);
            chk("cont", "idle_sel", 32'(sel1), 32'd0);
            for (int i = 0; i < 16; i++) begin
                step();
                chk("cont", "scan_busy", 32'(busy1), 32'd1);
                chk("cont", "scan_done", 32'(done1), 32'd0);
                chk("cont", "scan_sel", 32'(sel1), 32'(i / 2));
                chk("cont", "scan_data", 32'(data_out1), 32'hFF);
            end
            step();
            chk("cont", "done_n", 32'(done1), 32'd1);
            chk("cont", "busy_n", 32'(busy1), 32'd0);
            chk("cont", "data_n", 32'(data_out1), 32'hFF);
        end
        start1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
